// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register busy-bit scoreboard for a 4-slot VLIW issue stage.
// Slot order: 0=LSU, 1=IXU1, 2=IXU2, 3=BRANCH. Tracks outstanding writes per
// architectural register, blocks issue on RAW/WAW/intra-bundle conflicts, and
// supports drain-to-quiescence and flush.
// Optional feature: define SCOREBOARD_STALL_CNT_EN to build the saturating
// stall-cycle counter; otherwise o_stall_count is tied to zero.
module reg_scoreboard (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_issue_valid,
    input  logic [3:0]  i_slot_use,
    input  logic [19:0] i_slot_rs1,
    input  logic [19:0] i_slot_rs2,
    input  logic [19:0] i_slot_rd,
    input  logic [3:0]  i_slot_wr_en,
    output logic        o_issue_ready,
    input  logic [3:0]  i_wb_en,
    input  logic [19:0] i_wb_rd,
    input  logic        i_flush,
    input  logic        i_drain_req,
    output logic        o_drain_ack,
    output logic [31:0] o_pending,
    output logic        o_wb_err,
    output logic [15:0] o_stall_count
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StAck   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_drain_ack;
    logic [31:0] r_pending;
    logic        r_wb_err;

    logic [4:0]  w_rs1   [4];
    logic [4:0]  w_rs2   [4];
    logic [4:0]  w_rd    [4];
    logic [4:0]  w_wb_rd [4];
    logic        w_hazard;
    logic        w_accept;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic        w_wb_bad;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign w_rs1[g]   = i_slot_rs1[5*g +: 5];
        assign w_rs2[g]   = i_slot_rs2[5*g +: 5];
        assign w_rd[g]    = i_slot_rd[5*g +: 5];
        assign w_wb_rd[g] = i_wb_rd[5*g +: 5];
    end

    // Hazard detect against registered pending only (no writeback bypass).
    // Register 0 is never pending, so r0 sources/destinations never match.
    always_comb begin
        w_hazard = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (i_slot_use[n]) begin
                if (r_pending[w_rs1[n]] || r_pending[w_rs2[n]]) begin
                    w_hazard = 1'b1;
                end
                if (i_slot_wr_en[n] && r_pending[w_rd[n]]) begin
                    w_hazard = 1'b1;
                end
                for (int m = n + 1; m < 4; m++) begin
                    if (i_slot_use[m] && i_slot_wr_en[n] && i_slot_wr_en[m] &&
                        (w_rd[n] == w_rd[m]) && (w_rd[n] != 5'd0)) begin
                        w_hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign o_issue_ready = (r_state == StRun) && !w_hazard && !i_flush;
    assign w_accept      = i_issue_valid && o_issue_ready;

    // Build per-register set (accepted writes) and clear (writebacks) masks.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        w_wb_bad   = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (w_accept && i_slot_use[n] && i_slot_wr_en[n] && (w_rd[n] != 5'd0)) begin
                w_set_mask[w_rd[n]] = 1'b1;
            end
            if (i_wb_en[n] && (w_wb_rd[n] != 5'd0)) begin
                w_clr_mask[w_wb_rd[n]] = 1'b1;
                if (!r_pending[w_wb_rd[n]]) begin
                    w_wb_bad = 1'b1;
                end
            end
        end
    end

    // Pending bits: flush clears everything; set wins over clear; r0 held at 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else if (i_flush) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
        end
    end

    // Sticky writeback error; a flush cycle discards writebacks entirely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_err <= 1'b0;
        end else if (!i_flush && w_wb_bad) begin
            r_wb_err <= 1'b1;
        end
    end

    // Drain FSM with registered one-cycle acknowledge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StRun;
            r_drain_ack <= 1'b0;
        end else if (i_flush) begin
            r_state     <= StRun;
            r_drain_ack <= 1'b0;
        end else begin
            r_drain_ack <= 1'b0;
            case (r_state)
                StRun: begin
                    if (i_drain_req) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (r_pending == 32'd0) begin
                        r_state     <= StAck;
                        r_drain_ack <= 1'b1;
                    end
                end
                StAck: begin
                    r_state <= StRun;
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

`ifdef SCOREBOARD_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count offered-but-blocked cycles, saturating; flush cycles are not counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (i_issue_valid && !o_issue_ready && !i_flush &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_count = r_stall_cnt;
`else
    assign o_stall_count = 16'h0000;
`endif

    assign o_pending   = r_pending;
    assign o_wb_err    = r_wb_err;
    assign o_drain_ack = r_drain_ack;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed stimulus pushes expected values into a queue
// tagged with the cycle they apply to; a negedge monitor pops and compares.
module tb_reg_scoreboard;

    localparam int KRdy   = 0;
    localparam int KPend  = 1;
    localparam int KAck   = 2;
    localparam int KErr   = 3;
    localparam int KStall = 4;

`ifdef SCOREBOARD_STALL_CNT_EN
    localparam int LongN = 70000;
`else
    localparam int LongN = 20;
`endif

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [3:0]  slot_use;
    logic [19:0] slot_rs1;
    logic [19:0] slot_rs2;
    logic [19:0] slot_rd;
    logic [3:0]  slot_wr_en;
    logic        issue_ready;
    logic [3:0]  wb_en;
    logic [19:0] wb_rd;
    logic        flush;
    logic        drain_req;
    logic        drain_ack;
    logic [31:0] pending;
    logic        wb_err;
    logic [15:0] stall_count;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_stall;

    reg_scoreboard dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_issue_valid (issue_valid),
        .i_slot_use    (slot_use),
        .i_slot_rs1    (slot_rs1),
        .i_slot_rs2    (slot_rs2),
        .i_slot_rd     (slot_rd),
        .i_slot_wr_en  (slot_wr_en),
        .o_issue_ready (issue_ready),
        .i_wb_en       (wb_en),
        .i_wb_rd       (wb_rd),
        .i_flush       (flush),
        .i_drain_req   (drain_req),
        .o_drain_ack   (drain_ack),
        .o_pending     (pending),
        .o_wb_err      (wb_err),
        .o_stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            case (mon_e.kind)
                KRdy:    mon_act = {31'd0, issue_ready};
                KPend:   mon_act = pending;
                KAck:    mon_act = {31'd0, drain_ack};
                KErr:    mon_act = {31'd0, wb_err};
                default: mon_act = {16'd0, stall_count};
            endcase
            n_checks++;
            if (mon_e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (mon_act !== mon_e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                         mon_e.name, mon_act, mon_e.val, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        slot_use    = '0;
        slot_rs1    = '0;
        slot_rs2    = '0;
        slot_rd     = '0;
        slot_wr_en  = '0;
        wb_en       = '0;
        wb_rd       = '0;
        flush       = 1'b0;
        drain_req   = 1'b0;
    endtask

    task automatic slot(input int n, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wr);
        slot_use[n]         = 1'b1;
        slot_rs1[5*n +: 5]  = rs1;
        slot_rs2[5*n +: 5]  = rs2;
        slot_rd[5*n +: 5]   = rd;
        slot_wr_en[n]       = wr;
    endtask

    task automatic wb(input int n, input logic [4:0] rd);
        wb_en[n]          = 1'b1;
        wb_rd[5*n +: 5]   = rd;
    endtask

    task automatic exp_push(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Model of the stall counter: one increment per blocked offered cycle.
    task automatic note_stall();
`ifdef SCOREBOARD_STALL_CNT_EN
        if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        exp_stall = 16'd0;
        idle();
        step();
        exp_push(KPend, 32'd0, "rst_pending");
        exp_push(KAck, 32'd0, "rst_drain_ack");
        exp_push(KErr, 32'd0, "rst_wb_err");
        exp_push(KStall, 32'd0, "rst_stall_count");
        exp_push(KRdy, 32'd1, "rst_ready");
        step(); rst_n = 1'b1; idle();

        // RAW hazard and no-bypass release
        step(); idle(); issue_valid = 1'b1; slot(1, 0, 0, 5, 1);
        exp_push(KRdy, 32'd1, "raw_issue_ready");
        step(); idle(); exp_push(KPend, 32'h0000_0020, "raw_pend_set");
        issue_valid = 1'b1; slot(0, 5, 0, 0, 0); wb(1, 5);
        exp_push(KRdy, 32'd0, "raw_block_same_cycle_wb"); note_stall();
        step(); idle(); exp_push(KPend, 32'd0, "raw_pend_clr");
        issue_valid = 1'b1; slot(0, 5, 0, 0, 0);
        exp_push(KRdy, 32'd1, "raw_release");

        // Intra-bundle conflict, r0 destinations, same-bundle read
        step(); idle(); issue_valid = 1'b1; slot(1, 0, 0, 7, 1); slot(2, 0, 0, 7, 1);
        exp_push(KRdy, 32'd0, "intra_conflict"); note_stall();
        step(); idle(); exp_push(KPend, 32'd0, "intra_no_pend");
        issue_valid = 1'b1; slot(1, 0, 0, 0, 1); slot(2, 0, 0, 0, 1);
        exp_push(KRdy, 32'd1, "intra_r0_ok");
        step(); idle(); exp_push(KPend, 32'd0, "r0_never_pending");
        issue_valid = 1'b1; slot(0, 0, 0, 6, 1); slot(1, 6, 6, 0, 0);
        exp_push(KRdy, 32'd1, "same_bundle_read");
        step(); idle(); exp_push(KPend, 32'h0000_0040, "sbr_pend"); wb(0, 6);
        step(); idle(); exp_push(KPend, 32'd0, "sbr_clr");

        // WAW against pending
        issue_valid = 1'b1; slot(3, 0, 0, 10, 1);
        exp_push(KRdy, 32'd1, "waw_first");
        step(); idle(); exp_push(KPend, 32'h0000_0400, "waw_pend");
        issue_valid = 1'b1; slot(0, 0, 0, 10, 1); wb(2, 10);
        exp_push(KRdy, 32'd0, "waw_block"); note_stall();
        step(); idle(); exp_push(KPend, 32'd0, "waw_clr");
        exp_push(KStall, {16'd0, exp_stall}, "stall_count_early");

        // Writeback to r0 is ignored; writeback to non-pending sets wb_err
        wb(1, 0);
        step(); idle(); exp_push(KErr, 32'd0, "wb_r0_no_err");
        wb(0, 12); issue_valid = 1'b1; slot(1, 0, 0, 12, 1);
        exp_push(KRdy, 32'd1, "err_issue");
        step(); idle(); exp_push(KErr, 32'd1, "wb_err_set");
        exp_push(KPend, 32'h0000_1000, "set_wins_over_clr"); wb(2, 12);
        step(); idle(); exp_push(KPend, 32'd0, "r12_clr");
        exp_push(KErr, 32'd1, "wb_err_sticky");

        // Drain with issue accepted in the drain_req cycle
        issue_valid = 1'b1; slot(1, 0, 0, 3, 1); slot(2, 0, 0, 9, 1);
        exp_push(KRdy, 32'd1, "drain_pre_issue");
        step(); idle(); exp_push(KPend, 32'h0000_0208, "drain_pend_r3_r9");
        drain_req = 1'b1; issue_valid = 1'b1; slot(0, 0, 0, 4, 1);
        exp_push(KRdy, 32'd1, "issue_with_drain_req");
        step(); idle(); exp_push(KPend, 32'h0000_0218, "drain_pend_r4");
        exp_push(KRdy, 32'd0, "drain_ready_low");
        exp_push(KAck, 32'd0, "drain_ack_low0"); wb(0, 3); wb(1, 4);
        step(); idle(); exp_push(KPend, 32'h0000_0200, "drain_pend_r9");
        exp_push(KAck, 32'd0, "drain_ack_low1"); wb(3, 9);
        step(); idle(); exp_push(KPend, 32'd0, "drain_pend_zero");
        exp_push(KAck, 32'd0, "drain_ack_low2");
        step(); idle(); exp_push(KAck, 32'd1, "drain_ack_pulse");
        exp_push(KRdy, 32'd0, "ack_ready_low");
        step(); idle(); exp_push(KAck, 32'd0, "drain_ack_one_cycle");
        exp_push(KRdy, 32'd1, "back_to_run");

        // Flush during drain
        issue_valid = 1'b1;
        slot(0, 0, 0, 8, 1); slot(1, 0, 0, 9, 1); slot(2, 0, 0, 10, 1); slot(3, 0, 0, 11, 1);
        exp_push(KRdy, 32'd1, "flush_pre_issue");
        step(); idle(); exp_push(KPend, 32'h0000_0F00, "flush_pend_f00"); drain_req = 1'b1;
        step(); idle(); exp_push(KRdy, 32'd0, "in_drain_before_flush");
        flush = 1'b1; wb(0, 8);
        step(); idle(); exp_push(KPend, 32'd0, "flush_clears");
        exp_push(KRdy, 32'd1, "flush_to_run"); exp_push(KAck, 32'd0, "flush_no_ack0");
        step(); idle(); exp_push(KAck, 32'd0, "flush_no_ack1");
        exp_push(KErr, 32'd1, "flush_keeps_err");
        flush = 1'b1; issue_valid = 1'b1; slot(0, 0, 0, 13, 1);
        exp_push(KRdy, 32'd0, "flush_blocks_issue");
        step(); idle(); exp_push(KPend, 32'd0, "flush_no_accept");
        exp_push(KStall, {16'd0, exp_stall}, "flush_no_stall");

        // Long RAW stall
        issue_valid = 1'b1; slot(1, 0, 0, 5, 1);
        exp_push(KRdy, 32'd1, "long_pre_issue");
        step(); idle(); issue_valid = 1'b1; slot(0, 5, 0, 0, 0);
        exp_push(KRdy, 32'd0, "long_stall_start"); note_stall();
        for (int i = 1; i < LongN; i++) begin
            step(); note_stall();
        end
        exp_push(KRdy, 32'd0, "long_stall_end");
        step(); note_stall();
        exp_push(KStall, {16'd0, exp_stall}, "stall_count_long");
        exp_push(KPend, 32'h0000_0020, "long_pend");

        // Asynchronous reset mid-stall
        step(); rst_n = 1'b0; exp_stall = 16'd0;
        exp_push(KPend, 32'd0, "async_rst_pend");
        exp_push(KErr, 32'd0, "async_rst_err");
        exp_push(KStall, 32'd0, "async_rst_stall");
        exp_push(KAck, 32'd0, "async_rst_ack");
        exp_push(KRdy, 32'd1, "async_rst_ready");
        step(); rst_n = 1'b1; idle(); issue_valid = 1'b1; slot(0, 5, 0, 0, 0);
        exp_push(KRdy, 32'd1, "post_rst_ready");
        step(); idle(); exp_push(KPend, 32'd0, "post_rst_pend");

        repeat (3) step();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
